partoserial_tx: RTL and testbench

- Parallel-to-serial transmitter; the transmit end of the serial link whose receive end is the serialtopar/serialtopar0 converters.
- Accepts bytes through a valid/ready handshake and shifts them out MSB first, one bit per clk.
- Idle bytes are the comma 0xBC (K28.5).
- After reset it sends a fixed number of commas so the far-end receiver can synchronise. It also forces periodic commas during long data bursts.

---
 rtl/partoserial_tx.sv | 98 +++++++++
 tb/tb_partoserial_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/partoserial_tx.sv
// partoserial_tx: byte-wide valid/ready input, MSB-first serial output at one
// bit per clk. After reset it sends a run of commas so the far-end receiver
// can lock onto byte boundaries. Once active it inserts a comma whenever the
// link idles, and after every MAX_BURST consecutive data bytes.
module partoserial_tx #(
  parameter int          SYNC_COMMAS = 4,
  parameter int          MAX_BURST   = 16,
  parameter logic [7:0]  COMMA       = 8'hBC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out,
  output logic        active_out,
  output logic        comma_out,
  output logic [15:0] tx_count
);

  // burst_cnt only needs to reach MAX_BURST; keep at least one bit when forcing is off
  localparam int BURST_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic {
    SYNC,
    ACTIVE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [7:0]           shreg;
  logic [2:0]           bit_cnt;
  logic [3:0]           comma_cnt;
  logic [BURST_W-1:0]   burst_cnt;
  logic                 byte_end;
  logic                 force_comma;
  logic                 take;
  logic                 sync_done;

  // Byte-boundary decode, handshake and sync-to-active transition
  always_comb begin
    state_next  = state;
    byte_end    = (bit_cnt == 3'd7);
    force_comma = (MAX_BURST != 0) && (burst_cnt == BURST_W'(MAX_BURST));
    ready_out   = (state == ACTIVE) && byte_end && !force_comma;
    take        = valid_in && ready_out;
    sync_done   = (state == SYNC) && byte_end && (comma_cnt == 4'(SYNC_COMMAS - 1));
    if (sync_done) begin
      state_next = ACTIVE;
    end
  end

  // State register; only reset can return the transmitter to SYNC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SYNC;
    end else begin
      state <= state_next;
    end
  end

  // Shift register, bit/comma/burst counters and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= COMMA;
      bit_cnt    <= 3'd0;
      comma_cnt  <= 4'd0;
      burst_cnt  <= '0;
      active_out <= 1'b0;
      comma_out  <= 1'b1;
      tx_count   <= 16'd0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (!byte_end) begin
        shreg <= {shreg[6:0], 1'b0};
      end else if (state == SYNC) begin
        shreg     <= COMMA;
        comma_cnt <= comma_cnt + 4'd1;
        comma_out <= 1'b1;
        if (sync_done) begin
          active_out <= 1'b1;
        end
      end else if (take) begin
        shreg     <= data_in;
        comma_out <= 1'b0;
        tx_count  <= tx_count + 16'd1;
        burst_cnt <= burst_cnt + BURST_W'(1);
      end else begin
        shreg     <= COMMA;
        comma_out <= 1'b1;
        burst_cnt <= '0;
      end
    end
  end

  assign data_out = shreg[7];

endmodule

// File: tb/tb_partoserial_tx.sv
// tb_partoserial_tx: scoreboard bench for partoserial_tx. Every byte the
// transmitter should emit is pushed as 8 expected bits when the bench decides
// it at a byte boundary, and popped against data_out/comma_out each cycle.
module tb_partoserial_tx;

  localparam int         S     = 4;
  localparam int         MB    = 16;
  localparam logic [7:0] COMMA = 8'hBC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        ready_out, data_out, active_out, comma_out;
  logic [15:0] tx_count;
  logic        ready1, data1, active1, comma1;
  logic [15:0] tx1;

  typedef struct packed {
    logic b;
    logic c;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   m_cyc;
  int   m_burst;
  int   m_tx;
  int   n_chk = 0;
  int   n_pass = 0;

  partoserial_tx #(.SYNC_COMMAS(S), .MAX_BURST(MB), .COMMA(COMMA)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .active_out(active_out),
    .comma_out(comma_out), .tx_count(tx_count)
  );

  partoserial_tx #(.SYNC_COMMAS(1), .MAX_BURST(MB), .COMMA(COMMA)) dut1 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready1), .data_out(data1), .active_out(active1),
    .comma_out(comma1), .tx_count(tx1)
  );

  always #5 clk = ~clk;

  // Reference ready for the main instance
  function automatic logic m_ready();
    return (m_cyc >= 8*S + 7) && (m_cyc % 8 == 7) && (m_burst != MB);
  endfunction

  task automatic push_byte(input logic [7:0] v, input logic c);
    exp_t t;
    for (int i = 7; i >= 0; i--) begin
      t.b = v[i];
      t.c = c;
      exp_q.push_back(t);
    end
  endtask

  // Reset both instances, release on a falling edge; that half-cycle is cycle 0
  task automatic do_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    data_in = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    push_byte(COMMA, 1'b1);
    m_cyc = 0;
    m_burst = 0;
    m_tx = 0;
  endtask

  // Drive one cycle of inputs, decide the next byte at a boundary, step a clock
  task automatic advance(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in = d;
    if (m_cyc % 8 == 7) begin
      if (m_ready() && v) begin
        push_byte(d, 1'b0);
        m_tx++;
        m_burst++;
      end else begin
        push_byte(COMMA, 1'b1);
        m_burst = 0;
      end
    end
    @(negedge clk);
    m_cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (data_out !== 1'b1) $display("[TB] FAIL reset_data got %b want 1", data_out); else n_pass++;
    n_chk++; if (comma_out !== 1'b1) $display("[TB] FAIL reset_comma got %b want 1", comma_out); else n_pass++;
    n_chk++; if (active_out !== 1'b0) $display("[TB] FAIL reset_active got %b want 0", active_out); else n_pass++;
    n_chk++; if (ready_out !== 1'b0) $display("[TB] FAIL reset_ready got %b want 0", ready_out); else n_pass++;
    n_chk++; if (tx_count !== 16'd0) $display("[TB] FAIL reset_txcount got %0d want 0", tx_count); else n_pass++;
  endtask

  task automatic test_idle_sync();
    do_reset();
    for (int k = 0; k < 64; k++) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("[TB] FAIL idle_underrun cyc=%0d got empty want bit", m_cyc);
      end else begin
        e = exp_q.pop_front();
        n_chk++;
        if (data_out !== e.b || comma_out !== e.c)
          $display("[TB] FAIL idle_bit cyc=%0d got data=%b comma=%b want data=%b comma=%b", m_cyc, data_out, comma_out, e.b, e.c);
        else n_pass++;
      end
      n_chk++;
      if (ready_out !== m_ready()) $display("[TB] FAIL idle_ready cyc=%0d got %b want %b", m_cyc, ready_out, m_ready()); else n_pass++;
      n_chk++;
      if (active_out !== (m_cyc >= 8*S)) $display("[TB] FAIL idle_active cyc=%0d got %b want %b", m_cyc, active_out, m_cyc >= 8*S); else n_pass++;
      advance(1'b0, 8'h00);
    end
    n_chk++; if (tx_count !== 16'd0) $display("[TB] FAIL idle_txcount got %0d want 0", tx_count); else n_pass++;
  endtask

  task automatic test_single_byte();
    do_reset();
    for (int k = 0; k < 64; k++) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("[TB] FAIL single_underrun cyc=%0d got empty want bit", m_cyc);
      end else begin
        e = exp_q.pop_front();
        n_chk++;
        if (data_out !== e.b || comma_out !== e.c)
          $display("[TB] FAIL single_bit cyc=%0d got data=%b comma=%b want data=%b comma=%b", m_cyc, data_out, comma_out, e.b, e.c);
        else n_pass++;
      end
      n_chk++;
      if (ready_out !== m_ready()) $display("[TB] FAIL single_ready cyc=%0d got %b want %b", m_cyc, ready_out, m_ready()); else n_pass++;
      advance(m_cyc == 39, 8'hA5);
    end
    n_chk++; if (tx_count !== 16'd1) $display("[TB] FAIL single_txcount got %0d want 1", tx_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 260; k++) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("[TB] FAIL burst_underrun cyc=%0d got empty want bit", m_cyc);
      end else begin
        e = exp_q.pop_front();
        n_chk++;
        if (data_out !== e.b || comma_out !== e.c)
          $display("[TB] FAIL burst_bit cyc=%0d got data=%b comma=%b want data=%b comma=%b", m_cyc, data_out, comma_out, e.b, e.c);
        else n_pass++;
      end
      n_chk++;
      if (ready_out !== m_ready()) $display("[TB] FAIL burst_ready cyc=%0d got %b want %b", m_cyc, ready_out, m_ready()); else n_pass++;
      advance(m_tx < 20, 8'(m_tx + 1));
    end
    n_chk++; if (tx_count !== 16'd20) $display("[TB] FAIL burst_txcount got %0d want 20", tx_count); else n_pass++;
  endtask

  task automatic test_comma_data();
    do_reset();
    for (int k = 0; k < 56; k++) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("[TB] FAIL kdata_underrun cyc=%0d got empty want bit", m_cyc);
      end else begin
        e = exp_q.pop_front();
        n_chk++;
        if (data_out !== e.b || comma_out !== e.c)
          $display("[TB] FAIL kdata_bit cyc=%0d got data=%b comma=%b want data=%b comma=%b", m_cyc, data_out, comma_out, e.b, e.c);
        else n_pass++;
      end
      advance(m_cyc == 39, COMMA);
    end
    n_chk++; if (tx_count !== 16'd1) $display("[TB] FAIL kdata_txcount got %0d want 1", tx_count); else n_pass++;
  endtask

  task automatic test_reset_midbyte();
    do_reset();
    for (int k = 0; k < 44; k++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (data_out !== e.b || comma_out !== e.c)
        $display("[TB] FAIL midrst_pre cyc=%0d got data=%b comma=%b want data=%b comma=%b", m_cyc, data_out, comma_out, e.b, e.c);
      else n_pass++;
      advance(m_cyc == 39, 8'hA5);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++; if (data_out !== 1'b1) $display("[TB] FAIL midrst_data got %b want 1", data_out); else n_pass++;
    n_chk++; if (active_out !== 1'b0) $display("[TB] FAIL midrst_active got %b want 0", active_out); else n_pass++;
    n_chk++; if (tx_count !== 16'd0) $display("[TB] FAIL midrst_txcount got %0d want 0", tx_count); else n_pass++;
    n_chk++; if (comma_out !== 1'b1) $display("[TB] FAIL midrst_comma got %b want 1", comma_out); else n_pass++;
    do_reset();
    for (int k = 0; k < 48; k++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (data_out !== e.b || comma_out !== e.c)
        $display("[TB] FAIL midrst_post cyc=%0d got data=%b comma=%b want data=%b comma=%b", m_cyc, data_out, comma_out, e.b, e.c);
      else n_pass++;
      n_chk++;
      if (ready_out !== m_ready()) $display("[TB] FAIL midrst_ready cyc=%0d got %b want %b", m_cyc, ready_out, m_ready()); else n_pass++;
      advance(1'b0, 8'h00);
    end
  endtask

  task automatic test_sync_one();
    logic exp_rdy;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      exp_rdy = (m_cyc >= 15) && (m_cyc % 8 == 7);
      n_chk++;
      if (ready1 !== exp_rdy) $display("[TB] FAIL s1_ready cyc=%0d got %b want %b", m_cyc, ready1, exp_rdy); else n_pass++;
      n_chk++;
      if (active1 !== (m_cyc >= 8)) $display("[TB] FAIL s1_active cyc=%0d got %b want %b", m_cyc, active1, m_cyc >= 8); else n_pass++;
      n_chk++;
      if (data1 !== COMMA[7 - (m_cyc % 8)] || comma1 !== 1'b1)
        $display("[TB] FAIL s1_bit cyc=%0d got data=%b comma=%b want data=%b comma=1", m_cyc, data1, comma1, COMMA[7 - (m_cyc % 8)]);
      else n_pass++;
      advance(m_cyc % 8 != 7, 8'h5A);
    end
    n_chk++; if (tx1 !== 16'd0) $display("[TB] FAIL s1_txcount got %0d want 0", tx1); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_idle_sync();
    test_single_byte();
    test_back_to_back();
    test_comma_data();
    test_reset_midbyte();
    test_sync_one();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
